fetch_redirect_unit: RTL

Fetch-stage next-PC generator and branch-resolution tracker for the 5-stage core. It owns `PC_F`, steers fetch using the branch target buffer's `hit_F`/`target_F`, and carries each prediction through D to E. In E it compares the prediction against the actual outcome, raises a flush with a redirect PC on mispredict, and drives the BTB update port (`update_en`, `PC_E`, `target_E`).

---
 rtl/fetch_redirect_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_redirect_unit.sv
// Fetch next-PC generator with D/E prediction tracking and E-stage branch resolution.
// Optional performance counters are built only when BP_PERF_COUNTERS_EN is defined.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        hit_F,
    input  logic [31:0] target_F,
    input  logic        is_branch_E,
    input  logic        taken_E,
    input  logic [31:0] target_actual_E,
    output logic [31:0] PC_F,
    output logic        flush,
    output logic        update_en,
    output logic [31:0] PC_E,
    output logic [31:0] target_E,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic [31:0] pc_f_reg, pc_f_next;

    logic        valid_d_reg, pred_taken_d_reg;
    logic [31:0] pc_d_reg, pred_target_d_reg;

    logic        valid_e_reg, pred_taken_e_reg;
    logic [31:0] pc_e_reg, pred_target_e_reg;

    logic        resolve;
    logic        mispredict;
    logic [31:0] redirect_pc;

    always_comb begin
        resolve     = valid_e_reg && is_branch_E;
        mispredict  = 1'b0;
        redirect_pc = pc_e_reg + 32'd4;
        if (resolve) begin
            mispredict = (taken_E != pred_taken_e_reg) ||
                         (taken_E && pred_taken_e_reg && (target_actual_E != pred_target_e_reg));
            if (taken_E) begin
                redirect_pc = target_actual_E;
            end
        end else if (valid_e_reg && pred_taken_e_reg) begin
            // A non-branch predicted taken means the BTB entry aliased; fall through.
            mispredict = 1'b1;
        end
    end

    always_comb begin
        pc_f_next = pc_f_reg + 32'd4;
        if (mispredict) begin
            pc_f_next = redirect_pc;
        end else if (stall) begin
            pc_f_next = pc_f_reg;
        end else if (hit_F) begin
            pc_f_next = target_F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_reg          <= RESET_PC;
            valid_d_reg       <= 1'b0;
            pc_d_reg          <= 32'd0;
            pred_taken_d_reg  <= 1'b0;
            pred_target_d_reg <= 32'd0;
            valid_e_reg       <= 1'b0;
            pc_e_reg          <= 32'd0;
            pred_taken_e_reg  <= 1'b0;
            pred_target_e_reg <= 32'd0;
        end else begin
            pc_f_reg <= pc_f_next;

            if (mispredict) begin
                valid_d_reg <= 1'b0;
            end else if (!stall) begin
                valid_d_reg       <= 1'b1;
                pc_d_reg          <= pc_f_reg;
                pred_taken_d_reg  <= hit_F;
                pred_target_d_reg <= target_F;
            end

            // Payload always advances; only the valid bit encodes bubbles.
            valid_e_reg       <= valid_d_reg && !mispredict && !stall;
            pc_e_reg          <= pc_d_reg;
            pred_taken_e_reg  <= pred_taken_d_reg;
            pred_target_e_reg <= pred_target_d_reg;
        end
    end

    assign PC_F      = pc_f_reg;
    assign flush     = mispredict;
    assign update_en = resolve && taken_E;
    assign PC_E      = pc_e_reg;
    assign target_E  = target_actual_E;

`ifdef BP_PERF_COUNTERS_EN
    logic [1:0] cnt_inc;
    assign cnt_inc = {mispredict, resolve};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] count_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= 32'd0;
                end else if (cnt_inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign branch_count     = g_cnt[0].count_reg;
    assign mispredict_count = g_cnt[1].count_reg;
`else
    assign branch_count     = 32'd0;
    assign mispredict_count = 32'd0;
`endif

endmodule
